cdb_arbiter: RTL and testbench

Schedules the two common data bus ports (`cdb_pkt`, `cdb_pkt2`) among the functional-unit completion requesters (ALU, MUL, DIV, LSU, branch unit). Each cycle it grants at most two valid requesters with a rotating round-robin priority and registers the winners onto the CDB, which feeds the RAT, ROB and reservation stations. A branch-mispredict packet is always steered to `cdb_pkt2`, the port the RAT restores from, and is broadcast alone.

---
 rtl/rv32i_types.sv | 21 ++
 rtl/rr_pick2.sv | 39 +++
 rtl/cdb_arbiter.sv | 114 +++++++++++
 tb/tb_cdb_arbiter.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/rv32i_types.sv
// Shared CDB packet type and fixed requester index assignments.
package rv32i_types;

    // One CDB broadcast packet; cdb_broadcast marks a live entry on the bus.
    typedef struct packed {
        logic        cdb_broadcast;
        logic        br_mispred;
        logic [4:0]  rob_idx;
        logic [4:0]  rd;
        logic [31:0] data;
    } cdb_pkt_t;

    // Requester slots on the arbiter, independent of NUM_REQ.
    localparam int CDB_REQ_ALU = 0;
    localparam int CDB_REQ_MUL = 1;
    localparam int CDB_REQ_DIV = 2;
    localparam int CDB_REQ_LSU = 3;
    localparam int CDB_REQ_BR  = 4;
    localparam int CDB_REQ_CNT = 5;

endpackage

// File: rtl/rr_pick2.sv
// Rotating-priority picker: first and second set bits of a mask, scanning
// from ptr upward with modulo-NUM_REQ wrap (not power-of-two wrap).
module rr_pick2 #(
    parameter int NUM_REQ = 5,
    parameter int PW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [PW-1:0]      ptr,
    input  logic [NUM_REQ-1:0] req_mask,
    output logic [PW-1:0]      first_idx,
    output logic               first_found,
    output logic [PW-1:0]      second_idx,
    output logic               second_found
);

    int idx;

    // Walk the mask in scan order, latching the first two hits.
    always_comb begin
        first_idx    = '0;
        first_found  = 1'b0;
        second_idx   = '0;
        second_found = 1'b0;
        idx          = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(ptr) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (req_mask[idx]) begin
                if (!first_found) begin
                    first_found = 1'b1;
                    first_idx   = PW'(idx);
                end else if (!second_found) begin
                    second_found = 1'b1;
                    second_idx   = PW'(idx);
                end
            end
        end
    end

endmodule

// File: rtl/cdb_arbiter.sv
// Two-port common data bus arbiter. Round-robin grants of up to two
// completed FU results per cycle; a branch mispredict is broadcast alone on
// port 2 and is followed by one forced idle cycle so wrong-path FUs can flush.
module cdb_arbiter
    import rv32i_types::*;
#(
    parameter int NUM_REQ = 5
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_REQ-1:0]       req_valid,
    input  cdb_pkt_t [NUM_REQ-1:0]   req_pkt,
    output logic [NUM_REQ-1:0]       req_ready,
    output cdb_pkt_t                 cdb_pkt,
    output cdb_pkt_t                 cdb_pkt2
);

    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [PW-1:0]      rr_ptr_q, rr_ptr_d;
    cdb_pkt_t           cdb_pkt_q, cdb_pkt_d;
    cdb_pkt_t           cdb_pkt2_q, cdb_pkt2_d;
    logic [NUM_REQ-1:0] grant;

    logic [NUM_REQ-1:0] mp_mask;
    logic [NUM_REQ-1:0] pick_mask;
    logic               any_mp;
    logic               bubble;
    logic [PW-1:0]      first_idx, second_idx;
    logic               first_found, second_found;

    function automatic logic [PW-1:0] next_idx(input logic [PW-1:0] idx);
        return (idx == PW'(NUM_REQ - 1)) ? '0 : idx + PW'(1);
    endfunction

    // Previous cycle put a mispredict on the bus: this cycle is a flush bubble.
    assign bubble = cdb_pkt2_q.cdb_broadcast & cdb_pkt2_q.br_mispred;

    // Requesters that are both valid and carrying a mispredict.
    always_comb begin
        mp_mask = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            mp_mask[i] = req_valid[i] & req_pkt[i].br_mispred;
        end
    end

    assign any_mp = |mp_mask;

    // A single picker serves both modes: in mispredict mode only its first
    // winner is used, so feeding it the mispredict mask is sufficient.
    assign pick_mask = any_mp ? mp_mask : req_valid;

    rr_pick2 #(
        .NUM_REQ (NUM_REQ),
        .PW      (PW)
    ) u_pick (
        .ptr          (rr_ptr_q),
        .req_mask     (pick_mask),
        .first_idx    (first_idx),
        .first_found  (first_found),
        .second_idx   (second_idx),
        .second_found (second_found)
    );

    // Grant selection, next CDB contents and next round-robin pointer.
    always_comb begin
        grant      = '0;
        cdb_pkt_d  = '0;
        cdb_pkt2_d = '0;
        rr_ptr_d   = rr_ptr_q;
        if (!bubble) begin
            if (any_mp) begin
                // first_found is implied by any_mp
                grant[first_idx]         = 1'b1;
                cdb_pkt2_d               = req_pkt[first_idx];
                cdb_pkt2_d.cdb_broadcast = 1'b1;
                rr_ptr_d                 = next_idx(first_idx);
            end else begin
                if (first_found) begin
                    grant[first_idx]        = 1'b1;
                    cdb_pkt_d               = req_pkt[first_idx];
                    cdb_pkt_d.cdb_broadcast = 1'b1;
                    rr_ptr_d                = next_idx(first_idx);
                end
                if (second_found) begin
                    grant[second_idx]        = 1'b1;
                    cdb_pkt2_d               = req_pkt[second_idx];
                    cdb_pkt2_d.cdb_broadcast = 1'b1;
                    rr_ptr_d                 = next_idx(second_idx);
                end
            end
        end
    end

    // Ready is masked by reset so nothing handshakes while the flops are held.
    assign req_ready = grant & {NUM_REQ{rst_n}};

    // Pointer and CDB output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q   <= '0;
            cdb_pkt_q  <= '0;
            cdb_pkt2_q <= '0;
        end else begin
            rr_ptr_q   <= rr_ptr_d;
            cdb_pkt_q  <= cdb_pkt_d;
            cdb_pkt2_q <= cdb_pkt2_d;
        end
    end

    assign cdb_pkt  = cdb_pkt_q;
    assign cdb_pkt2 = cdb_pkt2_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter with NUM_REQ=5 and hand-computed grants.
module tb_cdb_arbiter;
    import rv32i_types::*;

    localparam int N = 5;

    logic               clk;
    logic               rst_n;
    logic [N-1:0]       req_valid;
    cdb_pkt_t [N-1:0]   req_pkt;
    logic [N-1:0]       req_ready;
    cdb_pkt_t           cdb_pkt;
    cdb_pkt_t           cdb_pkt2;

    int total = 0;
    int bad   = 0;

    cdb_arbiter #(.NUM_REQ(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_pkt   (req_pkt),
        .req_ready (req_ready),
        .cdb_pkt   (cdb_pkt),
        .cdb_pkt2  (cdb_pkt2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    function automatic cdb_pkt_t mk(input int i, input logic mp);
        cdb_pkt_t p;
        p               = '0;
        p.br_mispred    = mp;
        p.rob_idx       = 5'(i + 3);
        p.rd            = 5'(i + 1);
        p.data          = 32'hA000_0000 + 32'(i);
        return p;
    endfunction

    function automatic cdb_pkt_t bc(input cdb_pkt_t p);
        cdb_pkt_t q;
        q               = p;
        q.cdb_broadcast = 1'b1;
        return q;
    endfunction

    // One cycle: drive valid after negedge, check ready, check registered
    // outputs and pointer just after the following posedge.
    task automatic cyc(input string tag, input logic [N-1:0] v, input logic [N-1:0] er,
                       input cdb_pkt_t ep, input cdb_pkt_t ep2, input int err);
        req_valid = v;
        #1;
        chk({tag, ".ready"}, 64'(req_ready), 64'(er));
        @(posedge clk);
        #1;
        chk({tag, ".pkt"},  64'(cdb_pkt),  64'(ep));
        chk({tag, ".pkt2"}, 64'(cdb_pkt2), 64'(ep2));
        chk({tag, ".rr"},   64'(dut.rr_ptr_q), 64'(err));
        @(negedge clk);
    endtask

    cdb_pkt_t idle;
    cdb_pkt_t spec2;

    initial begin
        idle = '0;
        rst_n = 1'b0;
        req_valid = '1;
        for (int i = 0; i < N; i++) req_pkt[i] = mk(i, 1'b0);

        // Reset held with everything valid
        #3;
        chk("rst.ready", 64'(req_ready), 64'(0));
        chk("rst.bc1", 64'(cdb_pkt.cdb_broadcast), 64'(0));
        chk("rst.bc2", 64'(cdb_pkt2.cdb_broadcast), 64'(0));
        repeat (2) @(posedge clk);
        #1;
        chk("rst.hold.ready", 64'(req_ready), 64'(0));
        chk("rst.hold.pkt", 64'(cdb_pkt), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;

        // Round-robin wrap with all requesters valid
        cyc("rr0", 5'b11111, 5'b00011, bc(mk(0,0)), bc(mk(1,0)), 2);
        cyc("rr1", 5'b11111, 5'b01100, bc(mk(2,0)), bc(mk(3,0)), 4);
        cyc("rr2", 5'b11111, 5'b10001, bc(mk(4,0)), bc(mk(0,0)), 1);
        cyc("rr3", 5'b11111, 5'b00110, bc(mk(1,0)), bc(mk(2,0)), 3);

        // Single requester; second pass starts with rr_ptr=4
        cyc("one0", 5'b01000, 5'b01000, bc(mk(3,0)), idle, 4);
        cyc("one1", 5'b01000, 5'b01000, bc(mk(3,0)), idle, 4);

        // Mispredict on req 4 alongside reqs 0-2
        req_pkt[4] = mk(4, 1'b1);
        cyc("mp0", 5'b10111, 5'b10000, idle, bc(mk(4,1)), 0);
        req_pkt[4] = mk(4, 1'b0);
        cyc("mp.bub", 5'b00111, 5'b00000, idle, idle, 0);
        cyc("mp.after", 5'b00111, 5'b00011, bc(mk(0,0)), bc(mk(1,0)), 2);

        // Mispredict requester arriving during a bubble waits one cycle
        req_pkt[3] = mk(3, 1'b1);
        cyc("col0", 5'b01001, 5'b01000, idle, bc(mk(3,1)), 4);
        req_pkt[3] = mk(3, 1'b0);
        req_pkt[1] = mk(1, 1'b1);
        cyc("col.bub", 5'b00011, 5'b00000, idle, idle, 4);
        cyc("col.mp", 5'b00011, 5'b00010, idle, bc(mk(1,1)), 2);
        req_pkt[1] = mk(1, 1'b0);
        cyc("col.bub2", 5'b00001, 5'b00000, idle, idle, 2);
        cyc("col.norm", 5'b00001, 5'b00001, bc(mk(0,0)), idle, 1);
        cyc("pre", 5'b00110, 5'b00110, bc(mk(1,0)), bc(mk(2,0)), 3);

        // Handshake hold: req 2 waits two cycles with a distinctive packet
        spec2 = '0;
        spec2.rob_idx = 5'd17;
        spec2.rd = 5'd9;
        spec2.data = 32'hDEAD_BEEF;
        req_pkt[2] = spec2;
        cyc("hold0", 5'b11111, 5'b11000, bc(mk(3,0)), bc(mk(4,0)), 0);
        cyc("hold1", 5'b00111, 5'b00011, bc(mk(0,0)), bc(mk(1,0)), 2);
        cyc("hold2", 5'b00100, 5'b00100, bc(spec2), idle, 3);
        cyc("hold.once", 5'b00000, 5'b00000, idle, idle, 3);
        req_pkt[2] = mk(2, 1'b0);

        // Async reset while the CDB is broadcasting
        req_valid = 5'b11111;
        @(posedge clk);
        #1;
        chk("ar.live", 64'(cdb_pkt), 64'(bc(mk(3,0))));
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar.pkt", 64'(cdb_pkt), 64'(0));
        chk("ar.pkt2", 64'(cdb_pkt2), 64'(0));
        chk("ar.ready", 64'(req_ready), 64'(0));
        chk("ar.rr", 64'(dut.rr_ptr_q), 64'(0));
        @(negedge clk);
        @(negedge clk);
        req_valid = '0;
        rst_n = 1'b1;
        cyc("ar.idle", 5'b00000, 5'b00000, idle, idle, 0);
        cyc("ar.first", 5'b11111, 5'b00011, bc(mk(0,0)), bc(mk(1,0)), 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
